// File: rtl/pipe_front_regs_if.sv
// Bus bundle for the IF/ID and ID/EX front-end pipeline registers.
// The master drives the stage inputs and controls; the slave (the register block) drives the register contents.
interface pipe_front_regs_if;
    logic        Stall_i;
    logic        NoOp_i;
    logic        Flush_i;
    logic [31:0] PC_i;
    logic [31:0] instr_i;
    logic [7:0]  ctrl_i;
    logic [31:0] RS1data_i;
    logic [31:0] RS2data_i;
    logic [31:0] imm_i;
    logic [4:0]  RS1addr_i;
    logic [4:0]  RS2addr_i;
    logic [4:0]  RdAddr_i;
    logic [9:0]  funct_i;

    logic [31:0] IFID_PC_o;
    logic [31:0] IFID_instr_o;
    logic        IFID_valid_o;
    logic [7:0]  IDEX_ctrl_o;
    logic [31:0] IDEX_RS1data_o;
    logic [31:0] IDEX_RS2data_o;
    logic [31:0] IDEX_imm_o;
    logic [4:0]  IDEX_RS1addr_o;
    logic [4:0]  IDEX_RS2addr_o;
    logic [4:0]  IDEX_RdAddr_o;
    logic [9:0]  IDEX_funct_o;
    logic        IDEX_valid_o;
    logic [15:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;
    logic [15:0] bubble_cnt_o;
    logic        stall_err_o;

    modport master (
        output Stall_i, NoOp_i, Flush_i, PC_i, instr_i, ctrl_i,
               RS1data_i, RS2data_i, imm_i, RS1addr_i, RS2addr_i, RdAddr_i, funct_i,
        input  IFID_PC_o, IFID_instr_o, IFID_valid_o,
               IDEX_ctrl_o, IDEX_RS1data_o, IDEX_RS2data_o, IDEX_imm_o,
               IDEX_RS1addr_o, IDEX_RS2addr_o, IDEX_RdAddr_o, IDEX_funct_o, IDEX_valid_o,
               stall_cnt_o, flush_cnt_o, bubble_cnt_o, stall_err_o
    );

    modport slave (
        input  Stall_i, NoOp_i, Flush_i, PC_i, instr_i, ctrl_i,
               RS1data_i, RS2data_i, imm_i, RS1addr_i, RS2addr_i, RdAddr_i, funct_i,
        output IFID_PC_o, IFID_instr_o, IFID_valid_o,
               IDEX_ctrl_o, IDEX_RS1data_o, IDEX_RS2data_o, IDEX_imm_o,
               IDEX_RS1addr_o, IDEX_RS2addr_o, IDEX_RdAddr_o, IDEX_funct_o, IDEX_valid_o,
               stall_cnt_o, flush_cnt_o, bubble_cnt_o, stall_err_o
    );
endinterface

// File: rtl/pipe_front_regs.sv
// IF/ID and ID/EX pipeline registers with stall/flush/bubble handling,
// saturating hazard event counters and a sticky back-to-back stall error flag.
module pipe_front_regs (
    input  logic               clk_i,
    input  logic               rst_i,
    pipe_front_regs_if.slave   bus
);

    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_instr;
    logic        r_ifid_valid;

    logic [7:0]  r_idex_ctrl;
    logic [31:0] r_idex_rs1data;
    logic [31:0] r_idex_rs2data;
    logic [31:0] r_idex_imm;
    logic [4:0]  r_idex_rs1addr;
    logic [4:0]  r_idex_rs2addr;
    logic [4:0]  r_idex_rdaddr;
    logic [9:0]  r_idex_funct;
    logic        r_idex_valid;

    logic        r_stall_run;
    logic        r_stall_err;

    logic [2:0]        w_cnt_evt;
    logic [2:0][15:0]  w_cnt;

    // IF/ID: stall dominates flush, so a flush arriving during a stall is dropped.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ifid_pc    <= '0;
            r_ifid_instr <= '0;
            r_ifid_valid <= 1'b0;
        end else if (!bus.Stall_i) begin
            r_ifid_pc <= bus.PC_i;
            if (bus.Flush_i) begin
                r_ifid_instr <= '0;
                r_ifid_valid <= 1'b0;
            end else begin
                r_ifid_instr <= bus.instr_i;
                r_ifid_valid <= 1'b1;
            end
        end
    end

    // ID/EX always advances; a bubble only kills control and validity.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_idex_ctrl    <= '0;
            r_idex_rs1data <= '0;
            r_idex_rs2data <= '0;
            r_idex_imm     <= '0;
            r_idex_rs1addr <= '0;
            r_idex_rs2addr <= '0;
            r_idex_rdaddr  <= '0;
            r_idex_funct   <= '0;
            r_idex_valid   <= 1'b0;
        end else begin
            r_idex_rs1data <= bus.RS1data_i;
            r_idex_rs2data <= bus.RS2data_i;
            r_idex_imm     <= bus.imm_i;
            r_idex_rs1addr <= bus.RS1addr_i;
            r_idex_rs2addr <= bus.RS2addr_i;
            r_idex_rdaddr  <= bus.RdAddr_i;
            r_idex_funct   <= bus.funct_i;
            if (bus.NoOp_i) begin
                r_idex_ctrl  <= '0;
                r_idex_valid <= 1'b0;
            end else begin
                r_idex_ctrl  <= bus.ctrl_i;
                r_idex_valid <= r_ifid_valid;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_run <= 1'b0;
            r_stall_err <= 1'b0;
        end else begin
            r_stall_run <= bus.Stall_i;
            if (bus.Stall_i && r_stall_run) begin
                r_stall_err <= 1'b1;
            end
        end
    end

    // Event order: 0 = stall, 1 = effective flush, 2 = bubble.
    assign w_cnt_evt = {bus.NoOp_i, bus.Flush_i & ~bus.Stall_i, bus.Stall_i};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [15:0] r_cnt;
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    r_cnt <= '0;
                end else if (w_cnt_evt[gi] && (r_cnt != 16'hFFFF)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
            assign w_cnt[gi] = r_cnt;
        end
    endgenerate

    assign bus.IFID_PC_o      = r_ifid_pc;
    assign bus.IFID_instr_o   = r_ifid_instr;
    assign bus.IFID_valid_o   = r_ifid_valid;
    assign bus.IDEX_ctrl_o    = r_idex_ctrl;
    assign bus.IDEX_RS1data_o = r_idex_rs1data;
    assign bus.IDEX_RS2data_o = r_idex_rs2data;
    assign bus.IDEX_imm_o     = r_idex_imm;
    assign bus.IDEX_RS1addr_o = r_idex_rs1addr;
    assign bus.IDEX_RS2addr_o = r_idex_rs2addr;
    assign bus.IDEX_RdAddr_o  = r_idex_rdaddr;
    assign bus.IDEX_funct_o   = r_idex_funct;
    assign bus.IDEX_valid_o   = r_idex_valid;
    assign bus.stall_cnt_o    = w_cnt[0];
    assign bus.flush_cnt_o    = w_cnt[1];
    assign bus.bubble_cnt_o   = w_cnt[2];
    assign bus.stall_err_o    = r_stall_err;

endmodule

// File: tb/tb_pipe_front_regs.sv
// Self-checking bench for pipe_front_regs: directed scenarios plus randomized
// traffic compared against a transaction-level model of the two pipeline registers.
module tb_pipe_front_regs;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    pipe_front_regs_if bus();

    pipe_front_regs dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    // Reference model state
    logic [31:0] m_ifid_pc, m_ifid_instr;
    logic        m_ifid_valid;
    logic [7:0]  m_ctrl;
    logic [31:0] m_rs1d, m_rs2d, m_imm;
    logic [4:0]  m_rs1a, m_rs2a, m_rda;
    logic [9:0]  m_funct;
    logic        m_idex_valid;
    logic [15:0] m_stall_cnt, m_flush_cnt, m_bubble_cnt;
    logic        m_prev_stall, m_err;

    logic [243:0] dut_all, model_all;
    assign dut_all = {bus.IFID_PC_o, bus.IFID_instr_o, bus.IFID_valid_o, bus.IDEX_ctrl_o,
                      bus.IDEX_RS1data_o, bus.IDEX_RS2data_o, bus.IDEX_imm_o,
                      bus.IDEX_RS1addr_o, bus.IDEX_RS2addr_o, bus.IDEX_RdAddr_o,
                      bus.IDEX_funct_o, bus.IDEX_valid_o,
                      bus.stall_cnt_o, bus.flush_cnt_o, bus.bubble_cnt_o, bus.stall_err_o};
    assign model_all = {m_ifid_pc, m_ifid_instr, m_ifid_valid, m_ctrl,
                        m_rs1d, m_rs2d, m_imm, m_rs1a, m_rs2a, m_rda,
                        m_funct, m_idex_valid,
                        m_stall_cnt, m_flush_cnt, m_bubble_cnt, m_err};

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic ev);
        int n;
        n = int'(v) + (ev ? 1 : 0);
        return (n > 65535) ? 16'hFFFF : 16'(n);
    endfunction

    task automatic model_reset();
        {m_ifid_pc, m_ifid_instr, m_ifid_valid, m_ctrl, m_rs1d, m_rs2d, m_imm} = '0;
        {m_rs1a, m_rs2a, m_rda, m_funct, m_idex_valid} = '0;
        {m_stall_cnt, m_flush_cnt, m_bubble_cnt, m_prev_stall, m_err} = '0;
    endtask

    // One clock edge worth of pipeline behaviour, evaluated from the rules.
    task automatic model_step();
        logic prior_valid;
        prior_valid = m_ifid_valid;
        if (!bus.Stall_i) begin
            m_ifid_pc    = bus.PC_i;
            m_ifid_instr = bus.Flush_i ? 32'h0 : bus.instr_i;
            m_ifid_valid = !bus.Flush_i;
        end
        m_rs1d = bus.RS1data_i; m_rs2d = bus.RS2data_i; m_imm = bus.imm_i;
        m_rs1a = bus.RS1addr_i; m_rs2a = bus.RS2addr_i; m_rda = bus.RdAddr_i;
        m_funct = bus.funct_i;
        m_ctrl       = bus.NoOp_i ? 8'h0 : bus.ctrl_i;
        m_idex_valid = bus.NoOp_i ? 1'b0 : prior_valid;
        m_stall_cnt  = sat_inc(m_stall_cnt, bus.Stall_i);
        m_flush_cnt  = sat_inc(m_flush_cnt, bus.Flush_i && !bus.Stall_i);
        m_bubble_cnt = sat_inc(m_bubble_cnt, bus.NoOp_i);
        if (bus.Stall_i && m_prev_stall) m_err = 1'b1;
        m_prev_stall = bus.Stall_i;
    endtask

    task automatic tick();
        @(posedge clk_i);
        if (rst_i) model_step();
        #1;
    endtask

    task automatic drive_idle();
        bus.Stall_i = 1'b0; bus.NoOp_i = 1'b0; bus.Flush_i = 1'b0;
        bus.PC_i = $urandom; bus.instr_i = $urandom; bus.ctrl_i = 8'($urandom);
        bus.RS1data_i = $urandom; bus.RS2data_i = $urandom; bus.imm_i = $urandom;
        bus.RS1addr_i = 5'($urandom); bus.RS2addr_i = 5'($urandom);
        bus.RdAddr_i = 5'($urandom); bus.funct_i = 10'($urandom);
    endtask

    // Asserts reset between edges, then releases it one unit after a rising edge.
    task automatic apply_reset();
        @(posedge clk_i);
        #3 rst_i = 1'b0;
        model_reset();
        @(posedge clk_i);
        #1 rst_i = 1'b1;
    endtask

    task automatic test_reset();
        drive_idle();
        #2;
        checks++;
        if (dut_all !== '0) begin
            failures++;
            $display("FAIL reset_initial got=%h want=0", dut_all);
        end
        rst_i = 1'b1;
        bus.Stall_i = 1'b1; bus.NoOp_i = 1'b1;
        tick(); tick();
        bus.Stall_i = 1'b0; bus.NoOp_i = 1'b0;
        tick(); tick();
        @(posedge clk_i);
        #3 rst_i = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_all !== '0) begin
            failures++;
            $display("FAIL reset_async got=%h want=0", dut_all);
        end
        tick();
        checks++;
        if (dut_all !== '0) begin
            failures++;
            $display("FAIL reset_held_edge got=%h want=0", dut_all);
        end
        #1 rst_i = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        apply_reset();
        drive_idle();
        bus.PC_i = 32'h4; bus.instr_i = 32'h00A00093; bus.ctrl_i = 8'hA5;
        tick();
        checks++;
        if (bus.IDEX_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL basic_first_edge_idex_valid got=%b want=0", bus.IDEX_valid_o);
        end
        tick();
        checks++;
        if ({bus.IFID_PC_o, bus.IFID_instr_o, bus.IFID_valid_o, bus.IDEX_valid_o, bus.IDEX_ctrl_o}
            !== {32'h4, 32'h00A00093, 1'b1, 1'b1, 8'hA5}) begin
            failures++;
            $display("FAIL basic_regs got pc=%h instr=%h v=%b idv=%b ctrl=%h want pc=4 instr=00a00093 v=1 idv=1 ctrl=a5",
                     bus.IFID_PC_o, bus.IFID_instr_o, bus.IFID_valid_o, bus.IDEX_valid_o, bus.IDEX_ctrl_o);
        end
        checks++;
        if ({bus.stall_cnt_o, bus.flush_cnt_o, bus.bubble_cnt_o, bus.stall_err_o} !== 49'h0) begin
            failures++;
            $display("FAIL basic_counters got s=%h f=%h b=%h e=%b want all 0",
                     bus.stall_cnt_o, bus.flush_cnt_o, bus.bubble_cnt_o, bus.stall_err_o);
        end
        $display("test_basic pc=%h instr=%h", bus.IFID_PC_o, bus.IFID_instr_o);
    endtask

    task automatic test_stall_bubble();
        apply_reset();
        drive_idle();
        bus.PC_i = 32'h100; bus.instr_i = 32'h00002083; bus.ctrl_i = 8'hFF;
        tick();
        bus.Stall_i = 1'b1; bus.NoOp_i = 1'b1;
        bus.PC_i = 32'h200; bus.instr_i = 32'hDEADBEEF;
        tick();
        checks++;
        if ({bus.IFID_PC_o, bus.IFID_instr_o, bus.IFID_valid_o} !== {32'h100, 32'h00002083, 1'b1}) begin
            failures++;
            $display("FAIL stall_hold got pc=%h instr=%h v=%b want pc=100 instr=00002083 v=1",
                     bus.IFID_PC_o, bus.IFID_instr_o, bus.IFID_valid_o);
        end
        checks++;
        if ({bus.IDEX_ctrl_o, bus.IDEX_valid_o, bus.stall_cnt_o, bus.bubble_cnt_o, bus.flush_cnt_o, bus.stall_err_o}
            !== {8'h0, 1'b0, 16'd1, 16'd1, 16'd0, 1'b0}) begin
            failures++;
            $display("FAIL bubble_idex got ctrl=%h v=%b s=%0d b=%0d f=%0d e=%b want ctrl=0 v=0 s=1 b=1 f=0 e=0",
                     bus.IDEX_ctrl_o, bus.IDEX_valid_o, bus.stall_cnt_o, bus.bubble_cnt_o,
                     bus.flush_cnt_o, bus.stall_err_o);
        end
        $display("test_stall_bubble s=%0d b=%0d", bus.stall_cnt_o, bus.bubble_cnt_o);
    endtask

    task automatic test_flush();
        apply_reset();
        drive_idle();
        tick();
        bus.Flush_i = 1'b1; bus.PC_i = 32'h300;
        tick();
        checks++;
        if ({bus.IFID_PC_o, bus.IFID_instr_o, bus.IFID_valid_o, bus.flush_cnt_o}
            !== {32'h300, 32'h0, 1'b0, 16'd1}) begin
            failures++;
            $display("FAIL flush_ifid got pc=%h instr=%h v=%b f=%0d want pc=300 instr=0 v=0 f=1",
                     bus.IFID_PC_o, bus.IFID_instr_o, bus.IFID_valid_o, bus.flush_cnt_o);
        end
        bus.Flush_i = 1'b0;
        tick();
        checks++;
        if ({bus.IDEX_valid_o, bus.IFID_valid_o} !== 2'b01) begin
            failures++;
            $display("FAIL flush_idex got idv=%b ifv=%b want idv=0 ifv=1", bus.IDEX_valid_o, bus.IFID_valid_o);
        end
        $display("test_flush f=%0d", bus.flush_cnt_o);
    endtask

    task automatic test_stall_flush();
        apply_reset();
        drive_idle();
        bus.PC_i = 32'h40; bus.instr_i = 32'h1234;
        tick();
        bus.Stall_i = 1'b1; bus.Flush_i = 1'b1; bus.PC_i = 32'h80; bus.instr_i = 32'h5678;
        tick();
        checks++;
        if ({bus.IFID_PC_o, bus.IFID_instr_o, bus.IFID_valid_o, bus.flush_cnt_o, bus.stall_cnt_o}
            !== {32'h40, 32'h1234, 1'b1, 16'd0, 16'd1}) begin
            failures++;
            $display("FAIL stall_flush got pc=%h instr=%h v=%b f=%0d s=%0d want pc=40 instr=1234 v=1 f=0 s=1",
                     bus.IFID_PC_o, bus.IFID_instr_o, bus.IFID_valid_o, bus.flush_cnt_o, bus.stall_cnt_o);
        end
        $display("test_stall_flush s=%0d f=%0d", bus.stall_cnt_o, bus.flush_cnt_o);
    endtask

    task automatic test_stall_err();
        apply_reset();
        drive_idle();
        bus.Stall_i = 1'b1; tick();
        bus.Stall_i = 1'b0; tick();
        bus.Stall_i = 1'b1; tick();
        checks++;
        if (bus.stall_err_o !== 1'b0) begin
            failures++;
            $display("FAIL err_nonconsecutive got=%b want=0", bus.stall_err_o);
        end
        tick();
        checks++;
        if (bus.stall_err_o !== 1'b1) begin
            failures++;
            $display("FAIL err_consecutive got=%b want=1", bus.stall_err_o);
        end
        bus.Stall_i = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (bus.stall_err_o !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky got=%b want=1", bus.stall_err_o);
        end
        apply_reset();
        checks++;
        if (bus.stall_err_o !== 1'b0) begin
            failures++;
            $display("FAIL err_reset_clear got=%b want=0", bus.stall_err_o);
        end
        $display("test_stall_err done");
    endtask

    task automatic test_reset_mid_stall();
        apply_reset();
        drive_idle();
        bus.PC_i = 32'hAAAA0000; bus.instr_i = 32'h11111111;
        tick();
        bus.Stall_i = 1'b1;
        tick();
        apply_reset();
        checks++;
        if ({bus.IFID_PC_o, bus.IFID_instr_o, bus.IFID_valid_o} !== 65'h0) begin
            failures++;
            $display("FAIL midstall_discard got pc=%h instr=%h v=%b want 0",
                     bus.IFID_PC_o, bus.IFID_instr_o, bus.IFID_valid_o);
        end
        bus.Stall_i = 1'b0; bus.PC_i = 32'hBBBB0004; bus.instr_i = 32'h22222222;
        tick();
        checks++;
        if ({bus.IFID_PC_o, bus.IFID_instr_o, bus.IFID_valid_o} !== {32'hBBBB0004, 32'h22222222, 1'b1}) begin
            failures++;
            $display("FAIL midstall_reload got pc=%h instr=%h v=%b want pc=bbbb0004 instr=22222222 v=1",
                     bus.IFID_PC_o, bus.IFID_instr_o, bus.IFID_valid_o);
        end
        $display("test_reset_mid_stall pc=%h", bus.IFID_PC_o);
    endtask

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            drive_idle();
            bus.Stall_i = ($urandom_range(0, 4) == 0);
            bus.Flush_i = ($urandom_range(0, 3) == 0);
            bus.NoOp_i  = ($urandom_range(0, 3) == 0);
            tick();
            checks++;
            if (dut_all !== model_all) begin
                failures++;
                $display("FAIL random_txn_%0d got=%h want=%h", n, dut_all, model_all);
            end else begin
                $display("txn %0d stall=%b flush=%b noop=%b pc=%h", n,
                         bus.Stall_i, bus.Flush_i, bus.NoOp_i, bus.IFID_PC_o);
            end
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        drive_idle();
        bus.Stall_i = 1'b1; bus.NoOp_i = 1'b1;
        repeat (65534) tick();
        checks++;
        if ({bus.stall_cnt_o, bus.bubble_cnt_o} !== {16'hFFFE, 16'hFFFE}) begin
            failures++;
            $display("FAIL sat_below got s=%h b=%h want fffe", bus.stall_cnt_o, bus.bubble_cnt_o);
        end
        repeat (3) tick();
        checks++;
        if ({bus.stall_cnt_o, bus.bubble_cnt_o, bus.flush_cnt_o, bus.stall_err_o}
            !== {16'hFFFF, 16'hFFFF, 16'h0, 1'b1}) begin
            failures++;
            $display("FAIL sat_hold got s=%h b=%h f=%h e=%b want s=ffff b=ffff f=0 e=1",
                     bus.stall_cnt_o, bus.bubble_cnt_o, bus.flush_cnt_o, bus.stall_err_o);
        end
        @(posedge clk_i);
        #3 rst_i = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_all !== '0) begin
            failures++;
            $display("FAIL sat_async_reset got=%h want=0", dut_all);
        end
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        bus.Stall_i = 1'b0; bus.NoOp_i = 1'b0;
        $display("test_saturation done");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_stall_bubble();
        test_flush();
        test_stall_flush();
        test_stall_err();
        test_reset_mid_stall();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
